// File: rtl/yuv_buffer_ctrl_pkg.sv
// yuv_pkg: shared constants and types for the YUV frame-buffer sequencer.
//   WIDTH / HEIGHT / TOTAL_SIZE : default frame geometry in pixels
//   ADDR_W                      : default buffer address width
//   BLOCK                       : DCT block edge length (8x8 blocks)
//   SEL_*                       : data_select component codes
//   state_t                     : sequencer FSM states
package yuv_pkg;

  localparam int WIDTH      = 32;
  localparam int HEIGHT     = 32;
  localparam int TOTAL_SIZE = WIDTH * HEIGHT;
  localparam int ADDR_W     = 19;
  localparam int BLOCK      = 8;

  localparam logic [1:0] SEL_Y    = 2'd0;
  localparam logic [1:0] SEL_CB   = 2'd1;
  localparam logic [1:0] SEL_CR   = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    FLUSH = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/yuv_buffer_ctrl_if.sv
// yuv_buffer_ctrl_if: handshake and address bus of the YUV buffer sequencer.
//   master : sequencer side (drives write/read addressing and status)
//   slave  : environment side (colour converter, DCT, frame control)
//   start, pix_valid, dct_ready            : environment -> sequencer
//   write_read, addr_in                    : buffer write port
//   addr_out, data_select, row_valid       : buffer read row / DCT feed
//   block_first, block_last                : row position inside a block
//   busy, frame_done                       : frame status
interface yuv_buffer_ctrl_if
  import yuv_pkg::*;
#(
  parameter int ADDR_W = yuv_pkg::ADDR_W
) ();

  logic              start;
  logic              pix_valid;
  logic              dct_ready;
  logic              write_read;
  logic [ADDR_W-1:0] addr_in;
  logic [ADDR_W-1:0] addr_out;
  logic [1:0]        data_select;
  logic              row_valid;
  logic              block_first;
  logic              block_last;
  logic              busy;
  logic              frame_done;

  modport master (
    input  start, pix_valid, dct_ready,
    output write_read, addr_in, addr_out, data_select, row_valid,
           block_first, block_last, busy, frame_done
  );

  modport slave (
    output start, pix_valid, dct_ready,
    input  write_read, addr_in, addr_out, data_select, row_valid,
           block_first, block_last, busy, frame_done
  );

endinterface

// File: rtl/yuv_buffer_ctrl_block_addr_gen.sv
// block_addr_gen: 8x8 block scan counters for the read phase.
// Holds the component / block-row / block-column / row counters and presents
// the registered row address, component select and block position flags.
//   load       : park on the first row of the frame (Y, block 0, row 0)
//   advance    : current row accepted, step to the next one
//   addr_out   : buffer address of the first pixel of the current row
//   data_select: component of the current row, SEL_NONE when not scanning
//   block_first/block_last : current row is row 0 / row 7 of its block
//   last_row   : current row is the final row of the frame
// Macro YUV_INTERLEAVE_EN: MCU-interleaved order (by, bx, c, r) instead of
// component-major order (c, by, bx, r).
module block_addr_gen #(
  parameter int WIDTH  = yuv_pkg::WIDTH,
  parameter int HEIGHT = yuv_pkg::HEIGHT,
  parameter int ADDR_W = yuv_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr_out,
  output logic [1:0]        data_select,
  output logic              block_first,
  output logic              block_last,
  output logic              last_row
);
  import yuv_pkg::*;

  localparam int BX_N = WIDTH / BLOCK;
  localparam int BY_N = HEIGHT / BLOCK;
  localparam int BX_W = (BX_N > 1) ? $clog2(BX_N) : 1;
  localparam int BY_W = (BY_N > 1) ? $clog2(BY_N) : 1;
  localparam logic [BX_W-1:0] BX_MAX = BX_W'(BX_N - 1);
  localparam logic [BY_W-1:0] BY_MAX = BY_W'(BY_N - 1);

  logic [1:0]        comp_r, comp_s;
  logic [BY_W-1:0]   by_r, by_s;
  logic [BX_W-1:0]   bx_r, bx_s;
  logic [2:0]        row_r, row_s;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        sel_r;
  logic              first_r;
  logic              last_r;

  // Buffer address of row `row` of block (by, bx): (by*8 + row)*WIDTH + bx*8.
  function automatic logic [ADDR_W-1:0] row_addr(input logic [BY_W-1:0] by,
                                                  input logic [BX_W-1:0] bx,
                                                  input logic [2:0]      row);
    row_addr = (ADDR_W'(by) * ADDR_W'(BLOCK) + ADDR_W'(row)) * ADDR_W'(WIDTH)
             + ADDR_W'(bx) * ADDR_W'(BLOCK);
  endfunction

  // Next position in scan order; row is always the innermost counter.
  always_comb begin
    comp_s = comp_r;
    by_s   = by_r;
    bx_s   = bx_r;
    row_s  = row_r + 3'd1;
    if (row_r == 3'd7) begin
`ifdef YUV_INTERLEAVE_EN
      if (comp_r == SEL_CR) begin
        comp_s = SEL_Y;
        if (bx_r == BX_MAX) begin
          bx_s = '0;
          if (by_r == BY_MAX) begin
            by_s = '0;
          end else begin
            by_s = by_r + BY_W'(1);
          end
        end else begin
          bx_s = bx_r + BX_W'(1);
        end
      end else begin
        comp_s = comp_r + 2'd1;
      end
`else
      if (bx_r == BX_MAX) begin
        bx_s = '0;
        if (by_r == BY_MAX) begin
          by_s = '0;
          if (comp_r == SEL_CR) begin
            comp_s = SEL_Y;
          end else begin
            comp_s = comp_r + 2'd1;
          end
        end else begin
          by_s = by_r + BY_W'(1);
        end
      end else begin
        bx_s = bx_r + BX_W'(1);
      end
`endif
    end else begin
      comp_s = comp_r;
    end
  end

  // Both orders finish on the Cr row 7 of the bottom-right block.
  assign last_row = (comp_r == SEL_CR) && (by_r == BY_MAX) &&
                    (bx_r == BX_MAX) && (row_r == 3'd7);

  // Scan counters and the registered row outputs derived from them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      comp_r  <= SEL_Y;
      by_r    <= '0;
      bx_r    <= '0;
      row_r   <= 3'd0;
      addr_r  <= '0;
      sel_r   <= SEL_NONE;
      first_r <= 1'b0;
      last_r  <= 1'b0;
    end else if (load) begin
      comp_r  <= SEL_Y;
      by_r    <= '0;
      bx_r    <= '0;
      row_r   <= 3'd0;
      addr_r  <= '0;
      sel_r   <= SEL_Y;
      first_r <= 1'b1;
      last_r  <= 1'b0;
    end else if (advance) begin
      if (last_row) begin
        comp_r  <= SEL_Y;
        by_r    <= '0;
        bx_r    <= '0;
        row_r   <= 3'd0;
        addr_r  <= '0;
        sel_r   <= SEL_NONE;
        first_r <= 1'b0;
        last_r  <= 1'b0;
      end else begin
        comp_r  <= comp_s;
        by_r    <= by_s;
        bx_r    <= bx_s;
        row_r   <= row_s;
        addr_r  <= row_addr(by_s, bx_s, row_s);
        sel_r   <= comp_s;
        first_r <= (row_s == 3'd0);
        last_r  <= (row_s == 3'd7);
      end
    end
  end

  assign addr_out    = addr_r;
  assign data_select = sel_r;
  assign block_first = first_r;
  assign block_last  = last_r;

endmodule

// File: rtl/yuv_buffer_ctrl.sv
// yuv_buffer_ctrl: YUV frame-buffer sequencer (top).
// Fills the buffer from the colour converter in raster order, then scans it
// as 8x8 blocks, one 8-pixel row per DCT handshake.  One frame per start.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : yuv_buffer_ctrl_if.master (start/pix_valid/dct_ready in;
//           write_read/addr_in, addr_out/data_select/row_valid,
//           block_first/block_last, busy/frame_done out)
// Macro YUV_INTERLEAVE_EN (handled in block_addr_gen) selects MCU-interleaved
// read order; undefined gives component-major order.
module yuv_buffer_ctrl #(
  parameter int WIDTH  = yuv_pkg::WIDTH,
  parameter int HEIGHT = yuv_pkg::HEIGHT,
  parameter int ADDR_W = yuv_pkg::ADDR_W
) (
  input  logic            clock,
  input  logic            reset,
  yuv_buffer_ctrl_if.master bus
);
  import yuv_pkg::*;

  localparam int TOTAL     = WIDTH * HEIGHT;
  localparam int CNT_W     = $clog2(TOTAL + 1);
  localparam int LAST_ADDR = TOTAL - 1;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              write_read_r, write_read_s;
  logic [ADDR_W-1:0] addr_in_r, addr_in_s;
  logic              row_valid_r, row_valid_s;
  logic              busy_r, busy_s;
  logic              frame_done_r, frame_done_s;
  logic              gen_load_s;
  logic              gen_advance_s;
  logic              gen_last_row_s;

  // Next state and next registered outputs.
  // The buffer has a pixel register in front of its write port, so each
  // accepted pixel stores the previous one (address = count before it - 1).
  // Once all pixels are counted, FLUSH stores the one still held there.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    write_read_s  = 1'b0;
    addr_in_s     = addr_in_r;
    row_valid_s   = 1'b0;
    busy_s        = busy_r;
    frame_done_s  = 1'b0;
    gen_load_s    = 1'b0;
    gen_advance_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = WRITE;
          cnt_s   = '0;
          busy_s  = 1'b1;
        end else begin
          busy_s  = 1'b0;
        end
      end
      WRITE: begin
        if (cnt_r == CNT_W'(TOTAL)) begin
          state_s      = FLUSH;
          write_read_s = 1'b1;
          addr_in_s    = ADDR_W'(LAST_ADDR);
        end else if (bus.pix_valid) begin
          cnt_s = cnt_r + CNT_W'(1);
          if (cnt_r != '0) begin
            write_read_s = 1'b1;
            addr_in_s    = ADDR_W'(cnt_r - CNT_W'(1));
          end else begin
            write_read_s = 1'b0;
          end
        end else begin
          write_read_s = 1'b0;
        end
      end
      FLUSH: begin
        state_s     = READ;
        row_valid_s = 1'b1;
        gen_load_s  = 1'b1;
      end
      READ: begin
        row_valid_s = 1'b1;
        if (bus.dct_ready) begin
          gen_advance_s = 1'b1;
          if (gen_last_row_s) begin
            state_s      = DONE;
            row_valid_s  = 1'b0;
            frame_done_s = 1'b1;
          end else begin
            row_valid_s  = 1'b1;
          end
        end else begin
          gen_advance_s = 1'b0;
        end
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Write counter and registered write/status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r        <= '0;
      write_read_r <= 1'b0;
      addr_in_r    <= '0;
      row_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      cnt_r        <= cnt_s;
      write_read_r <= write_read_s;
      addr_in_r    <= addr_in_s;
      row_valid_r  <= row_valid_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
    end
  end

  block_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_block_addr_gen (
    .clock       (clock),
    .reset       (reset),
    .load        (gen_load_s),
    .advance     (gen_advance_s),
    .addr_out    (bus.addr_out),
    .data_select (bus.data_select),
    .block_first (bus.block_first),
    .block_last  (bus.block_last),
    .last_row    (gen_last_row_s)
  );

  assign bus.write_read = write_read_r;
  assign bus.addr_in    = addr_in_r;
  assign bus.row_valid  = row_valid_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_yuv_buffer_ctrl.sv
// Scoreboard bench for yuv_buffer_ctrl: the driver pushes the expected
// buffer stores and the expected row sequence (built from the block-scan
// formula), a negedge monitor pops and compares whenever the DUT presents
// a store or a row handshake.
module tb_yuv_buffer_ctrl;
  localparam int W    = 32;
  localparam int H    = 32;
  localparam int AW   = 19;
  localparam int N    = W * H;
  localparam int ROWS = 3 * N / 8;

  logic clock;
  logic reset;

  yuv_buffer_ctrl_if #(.ADDR_W(AW)) bus ();

  yuv_buffer_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { int addr; int cyc; } wexp_t;
  typedef struct { int addr; int sel; int first; int last; } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_count = 0;
  int hs_count = 0;
  int done_count = 0;
  int done_exp = -1;
  bit hold_pending = 1'b0;
  bit rv_seen = 1'b0;
  int h_addr, h_sel, h_first, h_last;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Expected row order straight from the scan rules.
  function automatic void build_rows();
    rq.delete();
`ifdef YUV_INTERLEAVE_EN
    for (int by = 0; by < H / 8; by++)
      for (int bx = 0; bx < W / 8; bx++)
        for (int c = 0; c < 3; c++)
          for (int r = 0; r < 8; r++)
            rq.push_back('{(by * 8 + r) * W + bx * 8, c, int'(r == 0), int'(r == 7)});
`else
    for (int c = 0; c < 3; c++)
      for (int by = 0; by < H / 8; by++)
        for (int bx = 0; bx < W / 8; bx++)
          for (int r = 0; r < 8; r++)
            rq.push_back('{(by * 8 + r) * W + bx * 8, c, int'(r == 0), int'(r == 7)});
`endif
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compares stores, row handshakes, holds and frame_done.
  always @(negedge clock) begin
    wexp_t we;
    rexp_t re;
    int    idx;
    if (!reset) begin
      if (bus.write_read) begin
        check("write_vs_row_valid", int'(bus.row_valid), 0);
        if (wq.size() == 0) begin
          check("unexpected_write", int'(bus.write_read), 0);
        end else begin
          we = wq.pop_front();
          check("write_addr", int'(bus.addr_in), we.addr);
          check("write_cycle", cyc, we.cyc);
          wr_count++;
        end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        we = wq.pop_front();
        check("write_missing", int'(bus.write_read), 1);
      end

      if (bus.row_valid) begin
        rv_seen = 1'b1;
        if (hold_pending) begin
          check("hold_addr", int'(bus.addr_out), h_addr);
          check("hold_sel", int'(bus.data_select), h_sel);
          check("hold_first", int'(bus.block_first), h_first);
          check("hold_last", int'(bus.block_last), h_last);
        end
        if (bus.dct_ready) begin
          hold_pending = 1'b0;
          if (rq.size() == 0) begin
            check("unexpected_row", int'(bus.row_valid), 0);
          end else begin
            idx = hs_count;
            re  = rq.pop_front();
            check("row_addr", int'(bus.addr_out), re.addr);
            check("row_sel", int'(bus.data_select), re.sel);
            check("row_first", int'(bus.block_first), re.first);
            check("row_last", int'(bus.block_last), re.last);
`ifdef YUV_INTERLEAVE_EN
            if (idx == 0 || idx == 8 || idx == 16) begin
              check("spot_sel_mcu", int'(bus.data_select), idx / 8);
              check("spot_addr_mcu", int'(bus.addr_out), 0);
            end
            if (idx == 23) check("spot_addr_23", int'(bus.addr_out), 224);
            if (idx == 24) begin
              check("spot_addr_24", int'(bus.addr_out), 8);
              check("spot_sel_24", int'(bus.data_select), 0);
            end
`else
            if (idx == 0) begin
              check("spot_addr_0", int'(bus.addr_out), 0);
              check("spot_first_0", int'(bus.block_first), 1);
            end
            if (idx == 51) check("spot_addr_b12r3", int'(bus.addr_out), 368);
            if (idx == 128) begin
              check("spot_sel_128", int'(bus.data_select), 1);
              check("spot_addr_128", int'(bus.addr_out), 0);
            end
            if (idx == ROWS - 1) begin
              check("spot_sel_last", int'(bus.data_select), 2);
              check("spot_addr_last", int'(bus.addr_out), 1016);
              check("spot_blast_last", int'(bus.block_last), 1);
            end
`endif
            hs_count++;
            if (rq.size() == 0) done_exp = cyc + 1;
          end
        end else begin
          hold_pending = 1'b1;
          h_addr  = int'(bus.addr_out);
          h_sel   = int'(bus.data_select);
          h_first = int'(bus.block_first);
          h_last  = int'(bus.block_last);
        end
      end else begin
        hold_pending = 1'b0;
        if (rv_seen && rq.size() > 0) check("row_bubble", int'(bus.row_valid), 1);
      end

      if (bus.frame_done) begin
        check("done_cycle", cyc, done_exp);
        check("done_sel", int'(bus.data_select), 3);
        check("done_busy", int'(bus.busy), 1);
        done_count++;
        rv_seen  = 1'b0;
        done_exp = -1;
      end else if (done_exp == cyc) begin
        check("done_missing", int'(bus.frame_done), 1);
        done_exp = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_write_read"}, int'(bus.write_read), 0);
    check({tag, "_addr_in"}, int'(bus.addr_in), 0);
    check({tag, "_addr_out"}, int'(bus.addr_out), 0);
    check({tag, "_data_select"}, int'(bus.data_select), 3);
    check({tag, "_row_valid"}, int'(bus.row_valid), 0);
    check({tag, "_block_first"}, int'(bus.block_first), 0);
    check({tag, "_block_last"}, int'(bus.block_last), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_frame_done"}, int'(bus.frame_done), 0);
  endtask

  // mode 0: back-to-back, 1: every other cycle, 2: random gaps.
  task automatic write_pixels(input int mode, input int count);
    int sent = 0;
    bit alt = 1'b1;
    bit v;
    while (sent < count) begin
      if (mode == 0) begin
        v = 1'b1;
      end else if (mode == 1) begin
        v = alt;
        alt = ~alt;
      end else begin
        v = 1'($urandom_range(0, 1));
      end
      bus.pix_valid = v;
      bus.dct_ready = 1'($urandom_range(0, 1));
      if (v) begin
        sent++;
        if (sent >= 2) wq.push_back('{sent - 2, cyc + 1});
        if (sent == N) wq.push_back('{N - 1, cyc + 2});
      end
      tick();
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic run_frame(input int wmode, input int stall_row);
    int base_done;
    int budget = 0;
    int stall_left = 5;
    wr_count = 0;
    hs_count = 0;
    build_rows();
    base_done = done_count;
    bus.start = 1'b1;
    bus.pix_valid = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_after_start", int'(bus.busy), 1);
    write_pixels(wmode, N);
    while (done_count == base_done && budget < 4000) begin
      if (stall_row >= 0 && hs_count == stall_row && stall_left > 0) begin
        bus.dct_ready = 1'b0;
        stall_left--;
      end else if (stall_row >= 0) begin
        bus.dct_ready = 1'b1;
      end else begin
        bus.dct_ready = 1'($urandom_range(0, 1));
      end
      bus.pix_valid = 1'($urandom_range(0, 1));
      bus.start = (budget == 40);
      tick();
      budget++;
    end
    bus.start = 1'b0;
    bus.pix_valid = 1'b0;
    check("frame_completed", done_count, base_done + 1);
    tick();
    check("busy_after_done", int'(bus.busy), 0);
    check("rows_per_frame", hs_count, ROWS);
    check("writes_per_frame", wr_count, N);
    check("row_queue_left", rq.size(), 0);
    check("write_queue_left", wq.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.pix_valid = 1'b0;
    bus.dct_ready = 1'b0;
    repeat (3) tick();
    check_reset_values("por");
    reset = 1'b0;
    tick();

    // Frame aborted by reset after 100 pixels.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    write_pixels(0, 100);
    reset = 1'b1;
    wq.delete();
    #1;
    check_reset_values("midreset");
    tick();
    tick();
    reset = 1'b0;
    tick();

    run_frame(0, 10);
    run_frame(1, -1);
    run_frame(2, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
